// File: rtl/uart_rx_mmio_if.sv
// CPU-side bus and receive-strobe bundle for the memory-mapped UART receiver.
// Every strobe (rx_valid, rd_en, wr_valid) is a one-cycle valid with no ready:
// the slave accepts whatever is presented on the edge where the strobe is high.
interface uart_rx_mmio_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        irq;

  modport master (
    output rx_valid, rx_data, rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_data, rd_hit, irq
  );

  modport slave (
    input  rx_valid, rx_data, rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_data, rd_hit, irq
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// Receive FIFO for bytes from rx_uart, exposed to the CPU as DATA/STATUS
// read registers and a CTRL register whose bit 0 flushes the FIFO.
module uart_rx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0010,
  parameter int          DEPTH_BITS = 4
) (
  input  logic           clk,
  input  logic           i_reset,
  uart_rx_mmio_if.slave  bus
);
  localparam int          DEPTH       = 1 << DEPTH_BITS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'd8;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_BITS-1:0] wptr;
  logic [DEPTH_BITS-1:0] rptr;
  logic [DEPTH_BITS:0]   count;
  logic [DEPTH_BITS:0]   count_next;
  logic                  overrun;
  logic                  overrun_next;
  logic                  full;
  logic                  empty;
  logic                  data_rd;
  logic                  status_rd;
  logic                  flush;
  logic                  pop;
  logic                  push;
  logic                  overrun_event;
  logic [7:0]            count_b;
  logic [31:0]           status_word;
  logic                  unused_wr_bits;

  // count never exceeds DEPTH, so its MSB alone marks the full state
  assign full  = count[DEPTH_BITS];
  assign empty = (count == '0);

  assign data_rd   = bus.rd_en && (bus.rd_addr == BASE_ADDR);
  assign status_rd = bus.rd_en && (bus.rd_addr == STATUS_ADDR);
  assign flush     = bus.wr_valid && (bus.wr_addr == CTRL_ADDR) && bus.wr_data[0];
  assign unused_wr_bits = ^bus.wr_data[31:1];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands
  assign pop           = data_rd && !empty;
  assign push          = bus.rx_valid && (!full || pop) && !flush;
  assign overrun_event = bus.rx_valid && full && !pop && !flush;

  assign count_b     = 8'(count);
  assign status_word = {16'b0, count_b, 5'b0, overrun, full, !empty};

  always_comb begin
    count_next   = count;
    overrun_next = overrun;
    if (flush) begin
      count_next   = '0;
      overrun_next = 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + (DEPTH_BITS+1)'(1);
        2'b01:   count_next = count - (DEPTH_BITS+1)'(1);
        default: count_next = count;
      endcase
      // a fresh overrun outranks the clear-on-read of STATUS
      if (overrun_event)  overrun_next = 1'b1;
      else if (status_rd) overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      count   <= count_next;
      overrun <= overrun_next;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + DEPTH_BITS'(1);
        if (pop)  rptr <= rptr + DEPTH_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      bus.rd_data <= '0;
      bus.rd_hit  <= 1'b0;
      bus.irq     <= 1'b0;
    end else begin
      bus.irq <= !empty;
      if (data_rd) begin
        bus.rd_hit  <= 1'b1;
        bus.rd_data <= empty ? 32'd0 : {24'b0, mem[rptr]};
      end else if (status_rd) begin
        bus.rd_hit  <= 1'b1;
        bus.rd_data <= status_word;
      end else begin
        bus.rd_hit  <= 1'b0;
        bus.rd_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: a byte-queue model predicts DATA/STATUS reads.
module tb_uart_rx_mmio;
  localparam logic [31:0] BASE   = 32'hFFFF_0010;
  localparam logic [31:0] STAT   = 32'hFFFF_0014;
  localparam logic [31:0] CTRL   = 32'hFFFF_0018;
  localparam int          DEPTH  = 16;

  logic clk;
  logic i_reset;
  int   checks;
  int   failures;
  logic [7:0] exp_q[$];
  logic       model_ovr;
  logic [31:0] exp_w;

  uart_rx_mmio_if bus ();

  uart_rx_mmio dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = 32'h0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 32'h0;
    bus.wr_data  = 32'h0;
  endtask

  function automatic logic [31:0] status_exp();
    logic [7:0] c;
    c = 8'(exp_q.size());
    return {16'b0, c, 5'b0, model_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
  endfunction

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else model_ovr = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic read_data(input string tag);
    exp_w = (exp_q.size() == 0) ? 32'h0 : {24'b0, exp_q.pop_front()};
    bus.rd_en   = 1'b1;
    bus.rd_addr = BASE;
    step();
    bus.rd_en = 1'b0;
    chk({tag, "_hit"}, {31'b0, bus.rd_hit}, 32'h1);
    chk(tag, bus.rd_data, exp_w);
  endtask

  task automatic read_status(input string tag);
    exp_w = status_exp();
    model_ovr = 1'b0;
    bus.rd_en   = 1'b1;
    bus.rd_addr = STAT;
    step();
    bus.rd_en = 1'b0;
    chk({tag, "_hit"}, {31'b0, bus.rd_hit}, 32'h1);
    chk(tag, bus.rd_data, exp_w);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_ovr = 1'b0;
    idle_bus();
    i_reset = 1'b1;

    // reset state
    repeat (3) step();
    chk("rst_rd_data", bus.rd_data, 32'h0);
    chk("rst_rd_hit", {31'b0, bus.rd_hit}, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    i_reset = 1'b0;
    step();
    read_status("status_after_reset");
    chk("irq_after_reset", {31'b0, bus.irq}, 32'h0);

    // two bytes in, three reads out, irq timing
    push_byte(8'h41);
    chk("irq_lag_first_push", {31'b0, bus.irq}, 32'h0);
    push_byte(8'h42);
    chk("irq_rise", {31'b0, bus.irq}, 32'h1);
    read_data("data_41");
    read_data("data_42");
    chk("irq_hold_after_pop2", {31'b0, bus.irq}, 32'h1);
    read_data("data_empty");
    chk("irq_fall", {31'b0, bus.irq}, 32'h0);
    read_status("status_drained");

    // overflow: 17 pushes into 16 slots
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    read_status("status_overrun");
    read_status("status_overrun_cleared");
    for (int i = 0; i < 16; i++) read_data("data_overflow_drain");
    read_data("data_after_overflow");

    // full FIFO with same-cycle push and pop
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = BASE;
    exp_w = {24'b0, exp_q.pop_front()};
    exp_q.push_back(8'hAA);
    step();
    idle_bus();
    chk("full_pushpop_hit", {31'b0, bus.rd_hit}, 32'h1);
    chk("full_pushpop_data", bus.rd_data, exp_w);
    read_status("status_full_no_overrun");
    for (int i = 0; i < 16; i++) read_data("data_full_drain");
    chk("model_empty_after_drain", 32'(exp_q.size()), 32'h0);

    // flush beats a same-cycle push
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = CTRL;
    bus.wr_data  = 32'h1;
    exp_q.delete();
    model_ovr = 1'b0;
    step();
    idle_bus();
    read_status("status_after_flush");
    read_data("data_after_flush");

    // CTRL write of 0 does nothing; flush with same-cycle DATA read returns old head
    push_byte(8'h61);
    push_byte(8'h62);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = CTRL;
    bus.wr_data  = 32'h0;
    step();
    idle_bus();
    read_status("status_ctrl_zero");
    bus.wr_valid = 1'b1;
    bus.wr_addr  = CTRL;
    bus.wr_data  = 32'h1;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = BASE;
    exp_w = {24'b0, exp_q.pop_front()};
    exp_q.delete();
    step();
    idle_bus();
    chk("flush_read_data", bus.rd_data, exp_w);
    read_status("status_after_flush_read");

    // writes to DATA/STATUS are ignored
    push_byte(8'h77);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = BASE;
    bus.wr_data  = 32'h1;
    step();
    bus.wr_addr  = STAT;
    step();
    idle_bus();
    read_status("status_after_ignored_writes");
    read_data("data_after_ignored_writes");

    // unmapped read
    bus.rd_en   = 1'b1;
    bus.rd_addr = 32'h0000_0100;
    step();
    idle_bus();
    chk("unmapped_hit", {31'b0, bus.rd_hit}, 32'h0);
    chk("unmapped_data", bus.rd_data, 32'h0);

    // asynchronous reset with bytes buffered
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
    read_status("status_before_async_reset");
    chk("irq_before_async_reset", {31'b0, bus.irq}, 32'h1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("async_rst_rd_data", bus.rd_data, 32'h0);
    chk("async_rst_rd_hit", {31'b0, bus.rd_hit}, 32'h0);
    chk("async_rst_irq", {31'b0, bus.irq}, 32'h0);
    exp_q.delete();
    model_ovr = 1'b0;
    step();
    i_reset = 1'b0;
    step();
    read_status("status_after_async_reset");
    read_data("data_after_async_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped receive side of the CPU's UART path; the CPU-readable counterpart to the write-only transmit peripheral.
- Accepts bytes from rx_uart (rx_valid/rx_data) and buffers them in a FIFO.
- Exposes DATA and STATUS registers on the CPU read bus (rd_addr/rd_data), plus a write-side CTRL register for flushing.
- Sits beside ram on the CPU bus; the top level muxes rd_data using rd_hit.

Parameters:
BASE_ADDR, 32'hFFFF_0010, byte address of DATA; STATUS = BASE_ADDR+4, CTRL = BASE_ADDR+8
DEPTH_BITS, 4, log2 of FIFO depth (default depth 16)

Ports:
clk  input  1  system clock, all logic on rising edge
i_reset  input  1  asynchronous, active-high reset
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
rd_en  input  1  CPU read strobe for rd_addr this cycle
rd_addr  input  32  CPU read address (word aligned)
wr_valid  input  1  CPU write strobe
wr_addr  input  32  CPU write address
wr_data  input  32  CPU write data
rd_data  output  32  registered read data, valid the cycle after rd_en
rd_hit  output  1  registered; 1 when the previous-cycle read addressed this block
irq  output  1  level: FIFO non-empty

Behaviour:
- Reset (async assert, sync release): FIFO pointers 0, count 0, overrun 0, rd_data 0, rd_hit 0, irq 0. Reset during activity discards all buffered bytes immediately.
- FIFO: depth 2^DEPTH_BITS. Count width is DEPTH_BITS+1. Read and write pointers are DEPTH_BITS wide and wrap modulo depth.
- Push: rx_valid=1 and not full -> store rx_data, wptr+1, count+1.
- Push when full -> byte dropped and overrun set sticky.
- Push and pop in the same cycle while full -> both succeed. Count is unchanged and overrun is not set.
- Read latency is 1 cycle. On rd_en with a matching address: rd_hit<=1 next cycle and rd_data<=selected value. On a non-matching address, or rd_en=0: rd_hit<=0 and rd_data<=0.
- DATA read (rd_addr==BASE_ADDR):
  - Non-empty: rd_data<={24'b0, head byte}, pop (rptr+1, count-1).
  - Empty: rd_data<=0 with no pointer change.
  - A push in the same cycle as an empty-FIFO pop is still stored. No same-cycle bypass: the pop returns 0 and the byte remains.
- STATUS read (BASE_ADDR+4): rd_data<={16'b0, count zero-extended to 8 bits [15:8], 5'b0, overrun [2], full [1], nonempty [0]}.
  - Status reflects state before any same-cycle push.
  - Reading STATUS clears overrun. If an overrun event occurs in that same cycle, overrun stays set and the returned bit shows the pre-read value.
- CTRL write (wr_valid && wr_addr==BASE_ADDR+8 && wr_data[0]): flush, so pointers, count and overrun go to 0.
  - Flush wins over a same-cycle push; that byte is discarded and does not set overrun.
  - Flush wins over a same-cycle DATA read; the read returns the pre-flush head byte.
- Writes to DATA/STATUS are ignored. Writes to other addresses are ignored; the tx uart decodes its own.
- irq = (count!=0), registered from count, so it updates one cycle after a push or pop.
- Address compare is a full 32-bit equality; rd_addr[1:0] must be 0.

Test Plan:
- Reset then STATUS read -> rd_data=0x00000000, rd_hit=1 one cycle later; irq=0.
- Push 0x41, 0x42, then DATA, DATA, DATA reads -> 0x41, 0x42, 0x00; STATUS afterward =0x00000000; irq rises the cycle after the first push and falls after the second pop.
- Push 17 bytes 0x00..0x10 with no reads -> STATUS=0x00001007. Next STATUS=0x00001003 (overrun cleared). 16 DATA reads return 0x00..0x0F; 0x10 is lost.
- Fill to 16, then in one cycle push 0xAA and DATA read -> returns oldest byte 0x00, count stays 16, overrun stays 0, 0xAA is the last byte read out.
- Push 3 bytes, then CTRL write 0x1 while rx_valid=1 with 0x55 -> STATUS=0x00000000, next DATA read returns 0. Then write CTRL 0x0 -> no effect.
- Read an unmapped address 0x00000100 -> rd_hit=0, rd_data=0. Assert i_reset asynchronously mid-stream with 5 bytes buffered -> outputs 0 before the next clock edge, and count is 0 after release.
